// File: rtl/gate_op_pkg.sv
// Shared opcode and FSM state encodings for the gate-op arbiter slice.
package gate_op_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned ST_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_GRANT = 2'd1;
  localparam logic [ST_W-1:0] ST_EXEC  = 2'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/gate_unit_vec.sv
// Combinational WIDTH-bit bitwise gate unit built from per-bit gate primitives.
module gate_unit_vec
  import gate_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_xor;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    and  u_and  (w_and[g],  a[g], b[g]);
    or   u_or   (w_or[g],   a[g], b[g]);
    nand u_nand (w_nand[g], a[g], b[g]);
    nor  u_nor  (w_nor[g],  a[g], b[g]);
    xor  u_xor  (w_xor[g],  a[g], b[g]);
  end

  // Illegal opcodes yield zero data with the error flag raised.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = w_and;
      OP_OR:   y = w_or;
      OP_NAND: y = w_nand;
      OP_NOR:  y = w_nor;
      OP_XOR:  y = w_xor;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter/sequencer sharing one gate_unit_vec among NREQ requesters,
// returning a registered, ID-tagged result over a valid/ready handshake.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [OP_W*NREQ-1:0]  op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err
);

  logic [ST_W-1:0]  r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [ST_W-1:0]  w_state_nxt;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [IDW-1:0]   w_id_nxt;
  logic [OP_W-1:0]  w_op_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [IDW-1:0]   w_rid_nxt;
  logic             w_err_nxt;

  logic [IDW-1:0]   w_win;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  logic [OP_W-1:0]  w_op_arr [NREQ];
  logic [WIDTH-1:0] w_a_arr  [NREQ];
  logic [WIDTH-1:0] w_b_arr  [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign w_op_arr[g] = op[OP_W*g +: OP_W];
    assign w_a_arr[g]  = a[WIDTH*g +: WIDTH];
    assign w_b_arr[g]  = b[WIDTH*g +: WIDTH];
  end

  // First active request found scanning upward from r_ptr, wrapping at NREQ.
  always_comb begin : p_rr_pick
    logic           found;
    logic [IDW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    w_win = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = IDW'((int'(r_ptr) + i) % int'(NREQ));
      if (!found && req[idx]) begin
        found = 1'b1;
        w_win = idx;
      end
    end
  end

  gate_unit_vec #(.WIDTH(WIDTH)) u_gate (
    .op  (r_op),
    .a   (r_a),
    .b   (r_b),
    .y   (w_y),
    .err (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_gnt_nxt   = '0;
    w_valid_nxt = res_valid;
    w_data_nxt  = res_data;
    w_rid_nxt   = res_id;
    w_err_nxt   = res_err;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_id_nxt    = w_win;
          w_op_nxt    = w_op_arr[w_win];
          w_a_nxt     = w_a_arr[w_win];
          w_b_nxt     = w_b_arr[w_win];
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_ptr_nxt   = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_data_nxt  = w_y;
        w_err_nxt   = w_err;
        w_rid_nxt   = r_id;
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_id      <= w_id_nxt;
      r_op      <= w_op_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      gnt       <= w_gnt_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
      res_valid <= w_valid_nxt;
      res_data  <= w_data_nxt;
      res_id    <= w_rid_nxt;
      res_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter (WIDTH=8, NREQ=4).
module tb_gate_op_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] op;
  logic [W*N-1:0] a;
  logic [W*N-1:0] b;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_err;

  int ntests = 0;
  int nfail  = 0;
  int gcount = 0;
  int g3cnt  = 0;
  int g3_before;
  logic [W-1:0] exp_data [4];

  always #5 clk = ~clk;

  gate_op_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  // Grant pulses observed at the falling edge, where gnt is stable.
  always @(negedge clk) begin
    if (gnt != '0) gcount++;
    if (gnt[3]) g3cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_opnd(input int i, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    op[3*i +: 3] = o;
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0; res_ready = 1'b0;
    exp_data[0] = 8'h0F; exp_data[1] = 8'h88; exp_data[2] = 8'hEE; exp_data[3] = 8'h11;

    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data", 32'(res_data), 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);
    chk("rst_err", 32'(res_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single XOR request from requester 0
    set_opnd(0, 3'd4, 8'hF0, 8'hFF);
    res_ready = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = '0;
    @(negedge clk);
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    chk("t1_valid_early", 32'(res_valid), 32'h0);
    @(negedge clk);
    chk("t1_valid", 32'(res_valid), 32'h1);
    chk("t1_data", 32'(res_data), 32'h0F);
    chk("t1_id", 32'(res_id), 32'h0);
    chk("t1_err", 32'(res_err), 32'h0);
    @(negedge clk);
    chk("t1_valid_clr", 32'(res_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);

    // Round robin with all four requesting; reset first so ptr starts at 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_opnd(1, 3'd0, 8'hCC, 8'hAA);
    set_opnd(2, 3'd1, 8'hCC, 8'hAA);
    set_opnd(3, 3'd3, 8'hCC, 8'hAA);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
      if (k == 4) req = '0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("t2_valid%0d", k), 32'(res_valid), 32'h1);
      chk($sformatf("t2_id%0d", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("t2_data%0d", k), 32'(res_data), 32'(exp_data[k % 4]));
      @(negedge clk);
      chk($sformatf("t2_idle%0d", k), 32'(busy), 32'h0);
    end

    // NAND from requester 2 under backpressure; requester 0 arrives while busy
    set_opnd(2, 3'd2, 8'hAA, 8'h0F);
    res_ready = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    chk("t3_gnt", 32'(gnt), 32'h4);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_valid", 32'(res_valid), 32'h1);
    chk("t3_data", 32'(res_data), 32'hF5);
    chk("t3_id", 32'(res_id), 32'h2);
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_stall_valid%0d", k), 32'(res_valid), 32'h1);
      chk($sformatf("t3_stall_data%0d", k), 32'(res_data), 32'hF5);
      chk($sformatf("t3_stall_gnt%0d", k), 32'(gnt), 32'h0);
      chk($sformatf("t3_stall_busy%0d", k), 32'(busy), 32'h1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 32'(res_valid), 32'h0);
    chk("t3_release_idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t3_next_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_next_data", 32'(res_data), 32'h0F);
    chk("t3_next_id", 32'(res_id), 32'h0);
    @(negedge clk);
    chk("t3_next_idle", 32'(busy), 32'h0);

    // Illegal opcode from requester 1
    op[3*1 +: 3] = 3'd7;
    req = 4'b0010;
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", 32'(res_valid), 32'h1);
    chk("t4_err", 32'(res_err), 32'h1);
    chk("t4_data", 32'(res_data), 32'h00);
    chk("t4_id", 32'(res_id), 32'h1);
    @(negedge clk);
    chk("t4_valid_clr", 32'(res_valid), 32'h0);

    // Reset during EXEC aborts the operation; ptr is 2 beforehand
    op[3*1 +: 3] = 3'd0;
    req = 4'b1111;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_valid", 32'(res_valid), 32'h0);
    chk("t5_rst_data", 32'(res_data), 32'h0);
    chk("t5_rst_id", 32'(res_id), 32'h0);
    chk("t5_rst_err", 32'(res_err), 32'h0);
    @(negedge clk);
    chk("t5_no_result", 32'(res_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_data", 32'(res_data), 32'h0F);
    chk("t5_id", 32'(res_id), 32'h0);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 32'h0);

    // Requester 3 pulses req only while busy and must never be granted
    g3_before = g3cnt;
    req = 4'b0001;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'h1);
    chk("t6_busy0", 32'(busy), 32'h1);
    req = 4'b1000;
    @(negedge clk);
    chk("t6_busy1", 32'(busy), 32'h1);
    req = '0;
    @(negedge clk);
    chk("t6_valid", 32'(res_valid), 32'h1);
    chk("t6_busy2", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t6_valid_clr", 32'(res_valid), 32'h0);
    chk("t6_idle", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6_quiet_gnt%0d", k), 32'(gnt), 32'h0);
      chk($sformatf("t6_quiet_busy%0d", k), 32'(busy), 32'h0);
    end
    chk("t6_req3_never", 32'(g3cnt - g3_before), 32'h0);
    chk("grant_total", 32'(gcount), 32'd12);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
